// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DEF_N = 6;
  localparam int DEF_DW = 2 * DEF_N;
  localparam int DEF_CW = $clog2(DEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_restore_step #(
  parameter int N = 6
) (
  input  logic [N:0]   p,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   p_next,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] dvs_ext;
  logic         ge;

  // p is always below divisor between steps, so its top bit is zero and the
  // N+2-bit shift equals {p[N-1:0], bit_in}; the result always fits N+1 bits.
  assign shifted = {p, bit_in};
  assign dvs_ext = {2'b00, divisor};
  assign ge      = (shifted >= dvs_ext);
  assign q_bit   = ge;
  assign p_next  = (N+1)'(ge ? (shifted - dvs_ext) : shifted);

endmodule

// File: rtl/unsigned_seq_div_rs.sv
// Unsigned 2N/N sequential restoring divider: one quotient bit per clock, MSB first.
module unsigned_seq_div_rs
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output state_t         state
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  logic [N-1:0]   dvs_q;
  logic [2*N-1:0] work_q;
  logic [N:0]     p_q;
  logic [CW-1:0]  cnt;
  logic [N:0]     step_p;
  logic           q_bit;

  div_restore_step #(.N(N)) u_step (
    .p       (p_q),
    .bit_in  (work_q[2*N-1]),
    .divisor (dvs_q),
    .p_next  (step_p),
    .q_bit   (q_bit)
  );

  // Handshake: load is a one-cycle command with no backpressure and is honoured
  // in every state (a load mid-run aborts and restarts); done marks valid
  // quotient/remainder and stays high until the next load or rst.
  // work_q doubles as dividend shifter and quotient collector: dividend bits
  // leave at the MSB while quotient bits enter at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      dvs_q       <= '0;
      work_q      <= '0;
      p_q         <= '0;
      cnt         <= '0;
    end else if (load) begin
      dvs_q  <= divisor;
      work_q <= dividend;
      p_q    <= '0;
      cnt    <= '0;
      if (divisor == '0) begin
        state       <= DONE;
        quotient    <= '1;
        remainder   <= '0;
        busy        <= 1'b0;
        done        <= 1'b1;
        div_by_zero <= 1'b1;
      end else begin
        state       <= RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          p_q    <= step_p;
          work_q <= {work_q[2*N-2:0], q_bit};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= {work_q[2*N-2:0], q_bit};
            remainder <= step_p[N-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_seq_div_rs.sv
// Directed table plus multi-cycle corner sequences for unsigned_seq_div_rs (N=6).
module tb_unsigned_seq_div_rs;
  import div_pkg::*;

  localparam int N = 6;
  localparam int DW = 2 * N;
  localparam int LAT = 2 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic [DW-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          busy, done, div_by_zero;
  state_t        state;

  int errors = 0;
  int checks = 0;

  unsigned_seq_div_rs #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dvd;
    logic [N-1:0]  dvs;
    logic [DW-1:0] exp_q;
    logic [N-1:0]  exp_r;
    logic          exp_dbz;
    int            exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present operands before the edge, drop load just after it
  task automatic do_load(input logic [DW-1:0] dvd, input logic [N-1:0] dvs);
    @(negedge clk);
    load = 1'b1;
    dividend = dvd;
    divisor = dvs;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Loads an operation and counts edges until done; also watches busy/done overlap
  // and that the previous results stay on the outputs while iterating.
  task automatic run_op(input logic [DW-1:0] dvd, input logic [N-1:0] dvs,
                        output int lat, output bit overlap, output bit held);
    logic [DW-1:0] old_q;
    logic [N-1:0]  old_r;
    old_q = quotient;
    old_r = remainder;
    overlap = 1'b0;
    held = 1'b1;
    lat = -1;
    do_load(dvd, dvs);
    if (busy && done) overlap = 1'b1;
    if (done) lat = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      if (quotient !== old_q || remainder !== old_r) held = 1'b0;
      @(posedge clk);
      #1;
      if (busy && done) overlap = 1'b1;
      if (done) lat = i;
    end
  endtask

  int lat;
  bit overlap, held;
  logic [DW-1:0] snap_q;
  logic [N-1:0] snap_r;
  logic [DW-1:0] rdvd;
  bit seen;

  initial begin
    vecs[0]  = '{12'd100,  6'd7,  12'd14,   6'd2,  1'b0, LAT};
    vecs[1]  = '{12'd4095, 6'd63, 12'd65,   6'd0,  1'b0, LAT};
    vecs[2]  = '{12'd5,    6'd9,  12'd0,    6'd5,  1'b0, LAT};
    vecs[3]  = '{12'd200,  6'd0,  12'd4095, 6'd0,  1'b1, 0};
    vecs[4]  = '{12'd0,    6'd1,  12'd0,    6'd0,  1'b0, LAT};
    vecs[5]  = '{12'd4095, 6'd1,  12'd4095, 6'd0,  1'b0, LAT};
    vecs[6]  = '{12'd63,   6'd63, 12'd1,    6'd0,  1'b0, LAT};
    vecs[7]  = '{12'd2000, 6'd45, 12'd44,   6'd20, 1'b0, LAT};
    vecs[8]  = '{12'd1,    6'd63, 12'd0,    6'd1,  1'b0, LAT};
    vecs[9]  = '{12'd3000, 6'd50, 12'd60,   6'd0,  1'b0, LAT};
    vecs[10] = '{12'd4032, 6'd62, 12'd65,   6'd2,  1'b0, LAT};
    vecs[11] = '{12'd0,    6'd0,  12'd4095, 6'd0,  1'b1, 0};

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("reset quotient", 32'(quotient), 0);
    check("reset remainder", 32'(remainder), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset dbz", 32'(div_by_zero), 0);
    check("reset state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle no change", 32'({busy, done, state}), 32'({1'b0, 1'b0, IDLE}));

    // directed table
    for (int v = 0; v < 12; v++) begin
      run_op(vecs[v].dvd, vecs[v].dvs, lat, overlap, held);
      check($sformatf("v%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d quotient", v), 32'(quotient), 32'(vecs[v].exp_q));
      check($sformatf("v%0d remainder", v), 32'(remainder), 32'(vecs[v].exp_r));
      check($sformatf("v%0d dbz", v), 32'(div_by_zero), 32'(vecs[v].exp_dbz));
      check($sformatf("v%0d busy/done overlap", v), 32'(overlap), 0);
      check($sformatf("v%0d outputs held during run", v), 32'(held), 1);
      check($sformatf("v%0d state", v), 32'(state), 32'(DONE));
    end

    // results hold in DONE with load low
    snap_q = quotient;
    snap_r = remainder;
    repeat (5) @(posedge clk);
    #1;
    check("done hold q", 32'(quotient), 32'(snap_q));
    check("done hold r", 32'(remainder), 32'(snap_r));
    check("done hold flags", 32'({done, busy, div_by_zero}), 32'(3'b101));

    // a normal load after div-by-zero clears the flags on the load edge
    do_load(12'd100, 6'd7);
    check("post-dbz load flags", 32'({busy, done, div_by_zero}), 32'(3'b100));

    // mid-run reload: 100/7 aborted at cycle 5, 1000/33 restarted
    repeat (4) @(posedge clk);
    run_op(12'd1000, 6'd33, lat, overlap, held);
    check("reload latency", 32'(lat), LAT);
    check("reload quotient", 32'(quotient), 30);
    check("reload remainder", 32'(remainder), 10);

    // rst mid-run clears everything and no done follows
    do_load(12'd100, 6'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun rst quotient", 32'(quotient), 0);
    check("midrun rst remainder", 32'(remainder), 0);
    check("midrun rst flags", 32'({busy, done, div_by_zero}), 0);
    check("midrun rst state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("no done after rst", 32'(seen), 0);

    // load held high: restarts every edge, done never rises
    @(negedge clk);
    load = 1'b1;
    dividend = 12'd100;
    divisor = 6'd7;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || !busy) seen = 1'b1;
    end
    load = 1'b0;
    check("held load never done", 32'(seen), 0);
    run_op(12'd100, 6'd7, lat, overlap, held);
    check("after held load q", 32'(quotient), 14);

    // sweep every non-zero divisor against random dividends
    for (int d = 1; d < 64; d++) begin
      rdvd = DW'($urandom_range(4095, 0));
      run_op(rdvd, N'(d), lat, overlap, held);
      check($sformatf("sweep d=%0d latency", d), 32'(lat), LAT);
      check($sformatf("sweep %0d/%0d quotient", rdvd, d), 32'(quotient), 32'(rdvd) / 32'(d));
      check($sformatf("sweep %0d/%0d invariant", rdvd, d),
            32'(quotient) * 32'(d) + 32'(remainder), 32'(rdvd));
      check($sformatf("sweep d=%0d rem<dvs", d), 32'(remainder < N'(d)), 1);
      check($sformatf("sweep d=%0d overlap", d), 32'(overlap), 0);
      @(posedge clk);
      #1;
      check($sformatf("sweep d=%0d done held", d), 32'(done), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
